// File: rtl/z80_bus_pkg.sv
// Shared definitions for Z80 bus-side responders: FSM state encoding,
// strobe levels and default decode/vector values.
package z80_bus_pkg;

    // Responder transaction states; also exported on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        INTA = 2'd3
    } bus_state_t;

    // Z80 strobes are active low.
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    // Default decode window and IM2 vector.
    localparam logic [7:0] DEF_IO_BASE    = 8'h40;
    localparam logic [7:0] DEF_IO_MASK    = 8'hF0;
    localparam logic [7:0] DEF_IM2_VECTOR = 8'hE0;

    // Data returned to the CPU when a read is force-completed.
    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // True when the port lies inside the BASE/MASK window.
    function automatic logic port_hit(input logic [7:0] port,
                                      input logic [7:0] base,
                                      input logic [7:0] mask);
        return (port & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/z80_port_decode.sv
// Combinational I/O port decoder: window match plus backend offset.
module z80_port_decode
    import z80_bus_pkg::*;
#(
    parameter logic [7:0] BASE = DEF_IO_BASE,
    parameter logic [7:0] MASK = DEF_IO_MASK,
    parameter int         AW   = 4
) (
    input  logic [7:0]    i_port,
    output logic          o_match,
    output logic [AW-1:0] o_offset
);

    // Match against the window; the low AW bits select the backend register.
    always_comb begin
        o_match  = port_hit(i_port, BASE, MASK);
        o_offset = i_port[AW-1:0];
    end

endmodule

// File: rtl/z80_io_responder.sv
// Z80 I/O-space slave: turns IN/OUT cycles inside a port window into a
// req/ack backend handshake, stretches the CPU with wait_n until the
// backend answers (or a timeout forces completion), and serves an IM2
// vector during interrupt acknowledge.
//
// Backend handshake: bus_req is a level held high, with bus_we/bus_addr/
// bus_wdata stable, from the cycle after the CPU strobes until the backend
// returns a single-cycle bus_ack (bus_rdata valid in that same cycle), the
// timeout expires, the CPU abandons the cycle (iorq_n high) or reset. A
// request dropped without ack is abandoned; an ack arriving outside REQ is
// ignored.
module z80_io_responder
    import z80_bus_pkg::*;
#(
    parameter logic [7:0] BASE    = DEF_IO_BASE,
    parameter logic [7:0] MASK    = DEF_IO_MASK,
    parameter int         AW      = 4,
    parameter int         TIMEOUT = 16,
    parameter logic [7:0] VECTOR  = DEF_IM2_VECTOR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   A,
    input  logic [7:0]    cpu_dout,
    output logic [7:0]    cpu_din,
    output logic          cpu_din_oe,
    input  logic          m1_n,
    input  logic          iorq_n,
    input  logic          rd_n,
    input  logic          wr_n,
    output logic          wait_n,
    output logic          int_n,
    input  logic          irq,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [7:0]    bus_wdata,
    input  logic          bus_ack,
    input  logic [7:0]    bus_rdata,
    output logic          timeout_err,
    output bus_state_t    dbg_state
);

    localparam int CW = $clog2(TIMEOUT + 1);

    bus_state_t    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_irq_pend, w_irq_pend_nxt;
    logic          r_irq_q;
    logic [7:0]    r_cpu_din, w_cpu_din_nxt;
    logic          r_cpu_din_oe, w_cpu_din_oe_nxt;
    logic          r_wait_n, w_wait_n_nxt;
    logic          r_int_n;
    logic          r_bus_req, w_bus_req_nxt;
    logic          r_bus_we, w_bus_we_nxt;
    logic [AW-1:0] r_bus_addr, w_bus_addr_nxt;
    logic [7:0]    r_bus_wdata, w_bus_wdata_nxt;
    logic          r_timeout_err, w_timeout_err_nxt;
    logic          w_irq_clr;

    logic          w_match;
    logic [AW-1:0] w_offset;
    logic          w_io_hit;
    logic          w_inta;
    logic          w_irq_rise;
    logic          w_timeout;
    logic          w_unused_addr_hi;

    // Only the low address byte selects an I/O port.
    assign w_unused_addr_hi = ^A[15:8];

    z80_port_decode #(
        .BASE (BASE),
        .MASK (MASK),
        .AW   (AW)
    ) u_decode (
        .i_port   (A[7:0]),
        .o_match  (w_match),
        .o_offset (w_offset)
    );

    // Strobe qualification; strobes are already registered on clk by the CPU.
    always_comb begin
        w_io_hit   = (iorq_n == STROBE_ON) && (m1_n == STROBE_OFF) && w_match &&
                     ((rd_n == STROBE_ON) || (wr_n == STROBE_ON));
        w_inta     = (iorq_n == STROBE_ON) && (m1_n == STROBE_ON);
        w_irq_rise = irq & ~r_irq_q;
        w_timeout  = (r_cnt == CW'(TIMEOUT - 1));
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_cpu_din_nxt     = r_cpu_din;
        w_cpu_din_oe_nxt  = r_cpu_din_oe;
        w_wait_n_nxt      = r_wait_n;
        w_bus_req_nxt     = r_bus_req;
        w_bus_we_nxt      = r_bus_we;
        w_bus_addr_nxt    = r_bus_addr;
        w_bus_wdata_nxt   = r_bus_wdata;
        w_timeout_err_nxt = 1'b0;
        w_irq_clr         = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_inta) begin
                    w_state_nxt      = INTA;
                    w_cpu_din_nxt    = VECTOR;
                    w_cpu_din_oe_nxt = 1'b1;
                    w_irq_clr        = 1'b1;
                end else if (w_io_hit) begin
                    w_state_nxt     = REQ;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = (wr_n == STROBE_ON);
                    w_bus_addr_nxt  = w_offset;
                    w_bus_wdata_nxt = cpu_dout;
                    w_wait_n_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                end
            end
            REQ: begin
                if (iorq_n == STROBE_OFF) begin
                    // CPU abandoned the cycle: release everything, no data.
                    w_state_nxt   = IDLE;
                    w_bus_req_nxt = 1'b0;
                    w_wait_n_nxt  = 1'b1;
                end else if (bus_ack || w_timeout) begin
                    // Ack takes priority over a timeout in the same cycle.
                    w_state_nxt       = HOLD;
                    w_bus_req_nxt     = 1'b0;
                    w_wait_n_nxt      = 1'b1;
                    w_timeout_err_nxt = ~bus_ack;
                    if (!r_bus_we) begin
                        w_cpu_din_nxt    = bus_ack ? bus_rdata : TIMEOUT_RDATA;
                        w_cpu_din_oe_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HOLD, INTA: begin
                // Drive read data until the CPU ends its cycle.
                if (iorq_n == STROBE_OFF) begin
                    w_state_nxt      = IDLE;
                    w_cpu_din_oe_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // A new irq edge beats the acknowledge clear.
        if (w_irq_rise) begin
            w_irq_pend_nxt = 1'b1;
        end else if (w_irq_clr) begin
            w_irq_pend_nxt = 1'b0;
        end else begin
            w_irq_pend_nxt = r_irq_pend;
        end
    end

    // State, counter, IRQ latch and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_irq_pend    <= 1'b0;
            r_irq_q       <= 1'b0;
            r_cpu_din     <= 8'h00;
            r_cpu_din_oe  <= 1'b0;
            r_wait_n      <= 1'b1;
            r_int_n       <= 1'b1;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= 8'h00;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_irq_pend    <= w_irq_pend_nxt;
            r_irq_q       <= irq;
            r_cpu_din     <= w_cpu_din_nxt;
            r_cpu_din_oe  <= w_cpu_din_oe_nxt;
            r_wait_n      <= w_wait_n_nxt;
            r_int_n       <= ~w_irq_pend_nxt;
            r_bus_req     <= w_bus_req_nxt;
            r_bus_we      <= w_bus_we_nxt;
            r_bus_addr    <= w_bus_addr_nxt;
            r_bus_wdata   <= w_bus_wdata_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign cpu_din     = r_cpu_din;
    assign cpu_din_oe  = r_cpu_din_oe;
    assign wait_n      = r_wait_n;
    assign int_n       = r_int_n;
    assign bus_req     = r_bus_req;
    assign bus_we      = r_bus_we;
    assign bus_addr    = r_bus_addr;
    assign bus_wdata   = r_bus_wdata;
    assign timeout_err = r_timeout_err;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_z80_io_responder.sv
// Bench for z80_io_responder: CPU I/O cycles, backend responder, IM2 flow.
module tb_z80_io_responder;
    import z80_bus_pkg::*;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [15:0] A;
    logic [7:0] cpu_dout;
    logic [7:0] cpu_din;
    logic       cpu_din_oe;
    logic       m1_n, iorq_n, rd_n, wr_n;
    logic       wait_n, int_n;
    logic       irq;
    logic       bus_req, bus_we;
    logic [3:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic       timeout_err;
    bus_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // Expected backend requests {we, addr, wdata} and expected CPU read data.
    logic [12:0] exp_q[$];
    logic [7:0]  exp_rd_q[$];

    z80_io_responder #(
        .BASE (8'h40), .MASK (8'hF0), .AW (4), .TIMEOUT (TIMEOUT), .VECTOR (8'hE0)
    ) dut (
        .clk (clk), .reset (reset), .A (A), .cpu_dout (cpu_dout),
        .cpu_din (cpu_din), .cpu_din_oe (cpu_din_oe),
        .m1_n (m1_n), .iorq_n (iorq_n), .rd_n (rd_n), .wr_n (wr_n),
        .wait_n (wait_n), .int_n (int_n), .irq (irq),
        .bus_req (bus_req), .bus_we (bus_we), .bus_addr (bus_addr),
        .bus_wdata (bus_wdata), .bus_ack (bus_ack), .bus_rdata (bus_rdata),
        .timeout_err (timeout_err), .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare a new backend request with the head of the expected queue.
    task automatic score_req(input string name);
        logic [12:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_req_unexpected"}, 32'(bus_req), 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_req_fields"}, 32'({bus_we, bus_addr, bus_wdata}), 32'(e));
        end
    endtask

    // One CPU I/O (or memory) cycle with a backend answering after ack_dly
    // clocks; ack_dly = 0 means the backend never answers.
    task automatic io_cycle(input string name, input logic [15:0] addr, input bit is_wr,
                            input bit is_mem, input logic [7:0] wdata,
                            input int ack_dly, input logic [7:0] rdata);
        bit  hit, acked, done, prev_req, seen_low;
        int  n_rise, n_wait, n_to, n_oe, req_at;
        logic [7:0] exp_rd;
        hit   = !is_mem && ((addr[7:0] & 8'hF0) == 8'h40);
        acked = (ack_dly > 0) && (ack_dly <= TIMEOUT);
        if (hit) begin
            exp_q.push_back({is_wr, addr[3:0], wdata});
            if (!is_wr) exp_rd_q.push_back(acked ? rdata : 8'hFF);
        end
        A        = addr;
        cpu_dout = wdata;
        m1_n     = 1'b1;
        iorq_n   = is_mem;
        rd_n     = is_wr;
        wr_n     = !is_wr;
        done = 0; prev_req = 0; seen_low = 0;
        n_rise = 0; n_wait = 0; n_to = 0; n_oe = 0; req_at = -1;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            tick();
            bus_ack   = 1'b0;
            bus_rdata = ~rdata;
            if (bus_req && !prev_req) begin
                n_rise++;
                if (n_rise == 1) begin
                    check({name, "_req_latency"}, 32'(cyc), 32'd1);
                    score_req(name);
                    req_at = cyc;
                end
            end
            prev_req = bus_req;
            if (!wait_n) begin n_wait++; seen_low = 1; end
            if (timeout_err) n_to++;
            if (cpu_din_oe) n_oe++;
            if (seen_low && wait_n) done = 1;
            if (!hit && cyc >= 6) done = 1;
            if (!done && req_at > 0 && ack_dly > 0 && cyc == req_at + ack_dly - 1) begin
                bus_ack   = 1'b1;
                bus_rdata = rdata;
            end
        end
        if (hit) begin
            check({name, "_completed"}, 32'(done), 32'd1);
            check({name, "_wait_cycles"}, 32'(n_wait), acked ? 32'(ack_dly) : 32'(TIMEOUT));
            if (!is_wr) begin
                exp_rd = exp_rd_q.pop_front();
                check({name, "_cpu_din"}, 32'(cpu_din), 32'(exp_rd));
                check({name, "_oe"}, 32'(cpu_din_oe), 32'd1);
            end else begin
                check({name, "_oe"}, 32'(cpu_din_oe), 32'd0);
            end
        end else begin
            check({name, "_no_wait"}, 32'(n_wait), 32'd0);
            check({name, "_no_oe"}, 32'(n_oe), 32'd0);
        end
        // CPU keeps the strobes low a little longer; nothing may restart.
        repeat (2) begin
            tick();
            bus_ack = 1'b0;
            if (bus_req && !prev_req) n_rise++;
            prev_req = bus_req;
            if (timeout_err) n_to++;
        end
        check({name, "_hold_oe"}, 32'(cpu_din_oe), 32'(hit && !is_wr));
        check({name, "_hold_wait"}, 32'(wait_n), 32'd1);
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        tick();
        check({name, "_end_oe"}, 32'(cpu_din_oe), 32'd0);
        check({name, "_end_state"}, 32'(dbg_state), 32'(IDLE));
        check({name, "_req_count"}, 32'(n_rise), 32'(hit));
        check({name, "_timeout_err"}, 32'(n_to), 32'(hit && !acked));
    endtask

    // Stimulus and report
    initial begin
        reset = 1'b1; A = 16'h0000; cpu_dout = 8'h00; irq = 1'b0;
        m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        bus_ack = 1'b0; bus_rdata = 8'h00;
        repeat (3) tick();
        check("rst_cpu_din", 32'(cpu_din), 32'h00);
        check("rst_oe", 32'(cpu_din_oe), 32'd0);
        check("rst_wait_n", 32'(wait_n), 32'd1);
        check("rst_int_n", 32'(int_n), 32'd1);
        check("rst_bus", 32'({bus_req, bus_we, bus_addr, bus_wdata}), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0;
        tick();

        io_cycle("out43", 16'h0043, 1, 0, 8'h5A, 3, 8'h00);
        io_cycle("in47", 16'h0047, 0, 0, 8'h00, 5, 8'hC3);
        io_cycle("in47_timeout", 16'h0047, 0, 0, 8'h00, 0, 8'hC3);
        io_cycle("in80_nomatch", 16'h0080, 0, 0, 8'h00, 2, 8'h12);
        io_cycle("mem0040", 16'h0040, 0, 1, 8'h00, 2, 8'h12);
        io_cycle("in4f_ack_at_limit", 16'h124F, 0, 0, 8'h00, TIMEOUT, 8'h3C);
        io_cycle("in4e_ack_before_limit", 16'h004E, 0, 0, 8'h00, TIMEOUT - 1, 8'hA5);
        io_cycle("out40_ack1", 16'h0040, 1, 0, 8'h81, 1, 8'h00);
        io_cycle("out4a_timeout", 16'hFF4A, 1, 0, 8'h66, 0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] p, d;
            p = 8'h40 | 8'($urandom_range(0, 15));
            d = 8'($urandom_range(0, 255));
            io_cycle("rand_io", {8'h00, p}, ($urandom_range(0, 1) == 1), 0, d,
                     $urandom_range(1, 6), 8'($urandom_range(0, 255)));
        end

        // Strobe abort while waiting for the backend; late ack ignored.
        exp_q.push_back({1'b0, 4'h2, 8'h00});
        A = 16'h0042; cpu_dout = 8'h00; iorq_n = 1'b0; rd_n = 1'b0;
        tick();
        check("abort_req", 32'(bus_req), 32'd1);
        score_req("abort");
        tick(); tick();
        iorq_n = 1'b1; rd_n = 1'b1;
        tick();
        check("abort_req_drop", 32'(bus_req), 32'd0);
        check("abort_wait_n", 32'(wait_n), 32'd1);
        check("abort_oe", 32'(cpu_din_oe), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        bus_ack = 1'b1; bus_rdata = 8'h77;
        tick();
        bus_ack = 1'b0;
        check("late_ack_state", 32'(dbg_state), 32'(IDLE));
        check("late_ack_oe", 32'(cpu_din_oe), 32'd0);
        check("late_ack_terr", 32'(timeout_err), 32'd0);

        // Reset while in REQ, then a normal OUT.
        exp_q.push_back({1'b1, 4'h1, 8'h11});
        A = 16'h0041; cpu_dout = 8'h11; iorq_n = 1'b0; wr_n = 1'b0;
        tick();
        check("rreq_req", 32'(bus_req), 32'd1);
        score_req("rreq");
        tick(); tick();
        reset = 1'b1;
        tick();
        check("rreq_bus_req", 32'(bus_req), 32'd0);
        check("rreq_wait_n", 32'(wait_n), 32'd1);
        check("rreq_oe", 32'(cpu_din_oe), 32'd0);
        check("rreq_state", 32'(dbg_state), 32'(IDLE));
        reset = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
        tick();
        io_cycle("out4c_after_reset", 16'h004C, 1, 0, 8'h99, 2, 8'h00);

        // IM2 interrupt flow.
        irq = 1'b1;
        tick();
        check("irq_int_n_low", 32'(int_n), 32'd0);
        m1_n = 1'b0; iorq_n = 1'b0;
        tick();
        check("inta_vector", 32'(cpu_din), 32'hE0);
        check("inta_oe", 32'(cpu_din_oe), 32'd1);
        check("inta_int_n", 32'(int_n), 32'd1);
        check("inta_wait_n", 32'(wait_n), 32'd1);
        check("inta_no_req", 32'(bus_req), 32'd0);
        tick();
        check("inta_hold_vector", 32'({cpu_din_oe, cpu_din}), 32'h1E0);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick();
        check("inta_end_oe", 32'(cpu_din_oe), 32'd0);
        repeat (3) tick();
        check("irq_level_no_retrigger", 32'(int_n), 32'd1);
        irq = 1'b0;
        tick();
        irq = 1'b1; m1_n = 1'b0; iorq_n = 1'b0;
        tick();
        check("irq_set_wins", 32'(int_n), 32'd0);
        check("irq_set_wins_vec", 32'({cpu_din_oe, cpu_din}), 32'h1E0);
        m1_n = 1'b1; iorq_n = 1'b1;
        tick();
        m1_n = 1'b0; iorq_n = 1'b0;
        tick();
        check("inta2_clears", 32'(int_n), 32'd1);
        m1_n = 1'b1; iorq_n = 1'b1; irq = 1'b0;
        tick();

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("exp_rd_q_empty", 32'(exp_rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/z80_io_responder.md
Name: z80_io_responder

Overview:
- Bus-side counterpart to the tv80 CPU tops: a Z80 I/O-space slave that watches the CPU strobes and address.
- Decodes a port window and converts IN/OUT cycles into a simple req/ack register handshake toward a peripheral backend.
- Stretches the CPU cycle via wait_n until the backend answers, or until a timeout expires.
- Raises int_n and supplies an IM2 vector during the interrupt-acknowledge cycle.

Parameters:
- BASE, 8'h40, I/O port base; a port matches when (A[7:0] & MASK) == (BASE & MASK).
- MASK, 8'hF0, decode mask; the bits cleared in MASK form the backend offset.
- AW, 4, backend address width; bus_addr = A[AW-1:0].
- TIMEOUT, 16, maximum clk cycles to wait for bus_ack before forced completion (must be ≥2).
- VECTOR, 8'hE0, IM2 vector driven during INTA.

Ports:
- clk, in, 1: system clock, same clock as the CPU.
- reset, in, 1: synchronous, active-high reset.
- A, in, 16: CPU address bus; only A[7:0] is used.
- cpu_dout, in, 8: CPU data out (write data).
- cpu_din, out, 8: data to the CPU di input.
- cpu_din_oe, out, 1: this block owns the data bus; the top-level read mux uses it.
- m1_n, iorq_n, rd_n, wr_n, in, 1 each: CPU strobes.
- wait_n, out, 1: CPU wait request (active low).
- int_n, out, 1: CPU interrupt request (active low).
- irq, in, 1: peripheral interrupt source.
- bus_req, out, 1: backend request, level.
- bus_we, out, 1: 1 = write.
- bus_addr, out, AW: backend register offset.
- bus_wdata, out, 8: write data.
- bus_ack, in, 1: backend completion, single-cycle pulse.
- bus_rdata, in, 8: read data, valid when bus_ack = 1.
- timeout_err, out, 1: one-cycle pulse on forced completion.

Behaviour:
- Reset values: cpu_din = 8'h00, cpu_din_oe = 0, wait_n = 1, int_n = 1, bus_req = 0, bus_we = 0, bus_addr = 0, bus_wdata = 0, timeout_err = 0, state IDLE, irq_pend = 0, irq_q = 0.
- Strobes are used directly (they are CPU-registered on clk); no extra synchroniser.

State machine IDLE → REQ → HOLD → IDLE, plus IDLE → INTA → IDLE:
- IDLE → REQ: iorq_n = 0, m1_n = 1, address match, and (rd_n = 0 or wr_n = 0). On the next edge:
  - bus_req = 1, bus_we = ~wr_n.
  - bus_addr and bus_wdata (= cpu_dout) are captured.
  - wait_n = 0.
  - Timeout counter cleared.
  - wait_n therefore asserts 1 clk after the strobes, which is before the CPU's T2 sampling edge given cen halving.
- An unmatched port or a memory cycle leaves the block in IDLE; no outputs change.
- REQ:
  - Counter increments each cycle.
  - On bus_ack: bus_req = 0, wait_n = 1; for a read, cpu_din = bus_rdata and cpu_din_oe = 1; go to HOLD.
  - If the counter reaches TIMEOUT-1 without ack: same as ack, but read data = 8'hFF and timeout_err pulses for 1 cycle.
  - Ack and timeout in the same cycle: ack wins, no timeout_err.
- HOLD:
  - cpu_din and cpu_din_oe are held until iorq_n = 1, then cpu_din_oe = 0 and go to IDLE.
  - A new access cannot start until iorq_n has returned high, so each CPU cycle gives exactly one backend request.
- IDLE → INTA: m1_n = 0 and iorq_n = 0.
  - Next edge: cpu_din = VECTOR, cpu_din_oe = 1, irq_pend cleared. wait_n stays 1.
  - Exit when iorq_n = 1, with cpu_din_oe = 0.
- Interrupt:
  - irq_pend sets on the rising edge of irq (irq_q is the previous irq). int_n = ~irq_pend, registered.
  - A rising edge in the same cycle as the INTA clear: set wins.
  - Level-held irq does not re-trigger.
- Strobe abort: if iorq_n rises while in REQ, drop bus_req, set wait_n = 1 and go to IDLE. Any late ack is ignored.
- Synchronous reset mid-transaction: all outputs return to reset values on that edge. The backend must tolerate bus_req dropping.

Decomposition:
- Shared package z80_bus_pkg holds:
  - the state enum (IDLE, REQ, HOLD, INTA);
  - localparams for the strobe encodings;
  - the default BASE/MASK/VECTOR values, reused by future memory-side responders.
- One natural sub-module: z80_port_decode, the combinational match and offset extraction, parameterised by BASE/MASK/AW.
- The FSM, timeout counter and IRQ latch stay in the top module.

Test Plan:
- OUT (0x43),0x5A: bus_req rises 1 clk after iorq_n/wr_n go low, with bus_we = 1, bus_addr = 3, bus_wdata = 0x5A. wait_n = 0 until ack (driven 3 clks later); one request only.
- IN A,(0x47), bus_rdata = 0xC3 acked after 5 clks: wait_n low for 5 clks, cpu_din = 0xC3 with oe = 1 until iorq_n rises; the CPU reads 0xC3.
- IN from 0x47 with no ack: wait_n released after TIMEOUT = 16 cycles, cpu_din = 0xFF, timeout_err pulses once.
- IN from 0x80 (no match) and a memory read at 0x0040: no bus_req, wait_n stays 1, cpu_din_oe stays 0.
- IM2 interrupt:
  - irq rises: int_n = 0 next clk.
  - INTA cycle (m1_n, iorq_n low): cpu_din = 0xE0, int_n returns to 1.
  - irq held high afterwards: int_n stays 1.
- Reset asserted while in REQ: the next clk shows bus_req = 0, wait_n = 1, cpu_din_oe = 0; a subsequent OUT completes normally.
